// File: rtl/blake2b_pkg.sv
// Shared types and helpers for the blake2b request arbiter.
// Holds the arbiter FSM encoding and the beat-count rule.
package blake2b_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      WAIT_HASH,
      RESP
   } arb_state_t;

   localparam int HASH_BITS = 512;

   // A zero-length message still occupies one (padded) beat.
   function automatic logic [8:0] beats_for_len(
      input logic [7:0]  len,
      input int unsigned byts
   );
      int unsigned n;
      if (len == 8'd0) n = 1;
      else n = (32'(len) + byts - 1) / byts;
      return 9'(n);
   endfunction

endpackage

// File: rtl/blake2b_rr_arb.sv
// Combinational round-robin picker: first request at or after
// the pointer, wrapping, as one-hot grant plus index.
module blake2b_rr_arb #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   always_comb begin : pick
      int  j;
      logic found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr_i) + i;
         if (j >= N) j = j - N;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/blake2b_arb.sv
// Shares one blake2b core between N_REQ message sources, one whole
// message at a time, returning each digest tagged with its owner.
module blake2b_arb
   import blake2b_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int DAT_BYTS = 128,
   parameter int ID_BITS  = $clog2(N_REQ)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [N_REQ*DAT_BYTS*8-1:0] i_req_dat,
   input  logic [N_REQ-1:0]          i_req_val,
   input  logic [N_REQ-1:0]          i_req_sop,
   input  logic [N_REQ-1:0]          i_req_eop,
   input  logic [N_REQ*8-1:0]        i_req_byte_len,
   output logic [N_REQ-1:0]          o_req_rdy,
   output logic [DAT_BYTS*8-1:0]     o_core_dat,
   output logic                      o_core_val,
   output logic                      o_core_sop,
   output logic                      o_core_eop,
   output logic [7:0]                o_core_byte_len,
   input  logic                      i_core_rdy,
   input  logic [HASH_BITS-1:0]      i_core_hash,
   input  logic                      i_core_hash_val,
   output logic                      o_core_hash_rdy,
   output logic [HASH_BITS-1:0]      o_rsp_dat,
   output logic [ID_BITS-1:0]        o_rsp_id,
   output logic                      o_rsp_val,
   input  logic                      i_rsp_rdy,
   output logic                      o_err,
   output logic                      o_busy
);

   localparam int DW = DAT_BYTS * 8;

   arb_state_t           state_q, state_d;
   logic [ID_BITS-1:0]   gnt_q, gnt_d;
   logic [ID_BITS-1:0]   ptr_q, ptr_d;
   logic [ID_BITS-1:0]   rsp_id_q, rsp_id_d;
   logic [7:0]           len_q, len_d;
   logic [8:0]           cnt_q, cnt_d;
   logic [HASH_BITS-1:0] rsp_dat_q, rsp_dat_d;

   logic [N_REQ-1:0]     cand;
   logic [N_REQ-1:0]     pick_oh;
   logic [ID_BITS-1:0]   pick_idx;
   logic                 pick_any;
   logic                 lane_val;
   logic                 lane_sop;
   logic                 lane_eop;
   logic                 err;

   assign cand = i_req_val & i_req_sop;

   blake2b_rr_arb #(
      .N  (N_REQ),
      .IW (ID_BITS)
   ) u_rr (
      .req_i (cand),
      .ptr_i (ptr_q),
      .gnt_o (pick_oh),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign lane_val = i_req_val[gnt_q];
   assign lane_sop = i_req_sop[gnt_q];
   assign lane_eop = i_req_eop[gnt_q];

   always_comb begin
      state_d         = state_q;
      gnt_d           = gnt_q;
      ptr_d           = ptr_q;
      len_d           = len_q;
      cnt_d           = cnt_q;
      rsp_dat_d       = rsp_dat_q;
      rsp_id_d        = rsp_id_q;
      o_req_rdy       = '0;
      o_core_dat      = '0;
      o_core_val      = 1'b0;
      o_core_sop      = 1'b0;
      o_core_eop      = 1'b0;
      o_core_byte_len = '0;
      o_core_hash_rdy = 1'b0;
      err             = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Stray mid-message beats are swallowed so they cannot stall.
            o_req_rdy = i_req_val & ~i_req_sop & {N_REQ{~i_rst}};
            err       = |(i_req_val & ~i_req_sop);
            if (pick_any) begin
               gnt_d = pick_idx;
               len_d = '0;
               for (int i = 0; i < N_REQ; i++)
                  if (pick_oh[i]) len_d = len_d | i_req_byte_len[i*8 +: 8];
               cnt_d   = '0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            o_core_dat       = i_req_dat[gnt_q*DW +: DW];
            o_core_val       = lane_val;
            o_core_sop       = lane_sop;
            o_core_eop       = lane_eop;
            o_core_byte_len  = len_q;
            o_req_rdy[gnt_q] = i_core_rdy;
            if (lane_val && i_core_rdy) begin
               if (cnt_q != '1) cnt_d = cnt_q + 9'd1;
               if (lane_sop && cnt_q != '0) err = 1'b1;
               if (lane_eop) begin
                  state_d = WAIT_HASH;
                  if (cnt_q + 9'd1 != beats_for_len(len_q, DAT_BYTS))
                     err = 1'b1;
               end
            end
         end
         WAIT_HASH: begin
            o_core_hash_rdy = 1'b1;
            if (i_core_hash_val) begin
               rsp_dat_d = i_core_hash;
               rsp_id_d  = gnt_q;
               state_d   = RESP;
            end
         end
         RESP: begin
            if (i_rsp_rdy) begin
               ptr_d   = (gnt_q == ID_BITS'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         ptr_q     <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         rsp_dat_q <= '0;
         rsp_id_q  <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         ptr_q     <= ptr_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_id_q  <= rsp_id_d;
      end
   end

   assign o_rsp_dat = rsp_dat_q;
   assign o_rsp_id  = rsp_id_q;
   assign o_rsp_val = (state_q == RESP);
   assign o_busy    = (state_q != IDLE);
   assign o_err     = err & ~i_rst;

endmodule

// File: tb/tb_blake2b_arb.sv
// Directed bench for blake2b_arb; the bench stands in for the core
// and the requesters and checks grant order, forwarding and errors.
module tb_blake2b_arb;

   localparam int N  = 4;
   localparam int DB = 128;
   localparam int DW = DB * 8;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic [N*DW-1:0]   i_req_dat;
   logic [N-1:0]      i_req_val, i_req_sop, i_req_eop;
   logic [N*8-1:0]    i_req_byte_len;
   logic [N-1:0]      o_req_rdy;
   logic [DW-1:0]     o_core_dat;
   logic              o_core_val, o_core_sop, o_core_eop;
   logic [7:0]        o_core_byte_len;
   logic              i_core_rdy;
   logic [511:0]      i_core_hash;
   logic              i_core_hash_val;
   logic              o_core_hash_rdy;
   logic [511:0]      o_rsp_dat;
   logic [1:0]        o_rsp_id;
   logic              o_rsp_val;
   logic              i_rsp_rdy;
   logic              o_err;
   logic              o_busy;

   blake2b_arb #(.N_REQ(N), .DAT_BYTS(DB)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_dat(i_req_dat), .i_req_val(i_req_val),
      .i_req_sop(i_req_sop), .i_req_eop(i_req_eop),
      .i_req_byte_len(i_req_byte_len), .o_req_rdy(o_req_rdy),
      .o_core_dat(o_core_dat), .o_core_val(o_core_val),
      .o_core_sop(o_core_sop), .o_core_eop(o_core_eop),
      .o_core_byte_len(o_core_byte_len), .i_core_rdy(i_core_rdy),
      .i_core_hash(i_core_hash), .i_core_hash_val(i_core_hash_val),
      .o_core_hash_rdy(o_core_hash_rdy), .o_rsp_dat(o_rsp_dat),
      .o_rsp_id(o_rsp_id), .o_rsp_val(o_rsp_val),
      .i_rsp_rdy(i_rsp_rdy), .o_err(o_err), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;

   // per-lane traffic plan
   int nbeats[N], blen[N], nmsg[N], start[N], bidx[N];
   logic [511:0] dig[N];
   int hold;
   // observations from the last run
   int rsp_ids[$];
   logic [511:0] rsp_dats[$];
   int err_cnt, fwd_viol, hold_viol, hold_seen;
   int first_rdy[N], rsp_cyc[N], sop_cyc[N];
   int core_cyc, hash_cyc, rval_cyc, cyc;

   logic [511:0] abc_std;
   logic [511:0] abc_dig;

   task automatic idle_inputs();
      i_req_dat = '0; i_req_val = '0; i_req_sop = '0; i_req_eop = '0;
      i_req_byte_len = '0; i_core_rdy = 1'b0; i_core_hash = '0;
      i_core_hash_val = 1'b0; i_rsp_rdy = 1'b0;
   endtask

   task automatic cfg_clear();
      for (int l = 0; l < N; l++) begin
         nbeats[l] = 1; blen[l] = 0; nmsg[l] = 0;
         start[l] = 0; bidx[l] = 0;
      end
      hold = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      i_rst = 1'b1;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic run_traffic(input int nrsp, input int budget);
      int got, hold_left, tmr, cur, hid;
      logic pend;
      logic [511:0] hd;
      logic hs[N];
      rsp_ids.delete(); rsp_dats.delete();
      err_cnt = 0; fwd_viol = 0; hold_viol = 0; hold_seen = 0;
      core_cyc = -1; hash_cyc = -1; rval_cyc = -1; cyc = 0;
      for (int l = 0; l < N; l++) begin
         first_rdy[l] = -1; rsp_cyc[l] = -1; sop_cyc[l] = -1;
      end
      got = 0; hold_left = hold; tmr = 0; cur = 0; pend = 1'b0;
      hid = 0; hd = '0;
      while (got < nrsp && cyc < budget) begin
         for (int l = 0; l < N; l++) begin
            logic [31:0] w;
            w = 32'hA000_0000 | 32'(l << 8) | 32'(bidx[l]);
            if (nmsg[l] > 0 && cyc >= start[l]) begin
               i_req_val[l] = 1'b1;
               i_req_sop[l] = (bidx[l] == 0);
               i_req_eop[l] = (bidx[l] == nbeats[l] - 1);
               i_req_dat[l*DW +: DW] = {32{w}};
               i_req_byte_len[l*8 +: 8] = 8'(blen[l]);
               if (bidx[l] == 0 && sop_cyc[l] < 0) sop_cyc[l] = cyc;
            end else begin
               i_req_val[l] = 1'b0; i_req_sop[l] = 1'b0; i_req_eop[l] = 1'b0;
            end
         end
         i_core_rdy = 1'b1;
         i_core_hash_val = pend && tmr == 0;
         i_core_hash = dig[cur];
         i_rsp_rdy = (hold_left == 0);
         #1;
         if (o_err) err_cnt++;
         if (o_core_val && core_cyc < 0) core_cyc = cyc;
         for (int l = 0; l < N; l++) begin
            hs[l] = i_req_val[l] && o_req_rdy[l];
            if (hs[l] && first_rdy[l] < 0) first_rdy[l] = cyc;
         end
         if (i_core_hash_val && o_core_hash_rdy) begin
            pend = 1'b0; hash_cyc = cyc;
         end else if (pend && tmr > 0) tmr--;
         if (o_core_val && i_core_rdy) begin
            int hl;
            hl = -1;
            for (int l = 0; l < N; l++) if (hs[l]) hl = l;
            if (hl < 0) fwd_viol++;
            else begin
               if (o_core_dat !== i_req_dat[hl*DW +: DW] ||
                   o_core_sop !== i_req_sop[hl] ||
                   o_core_eop !== i_req_eop[hl] ||
                   o_core_byte_len !== 8'(blen[hl])) fwd_viol++;
               if (o_core_eop) begin
                  pend = 1'b1; tmr = 2; cur = hl;
               end
            end
         end
         if (o_rsp_val) begin
            if (rval_cyc < 0) rval_cyc = cyc;
            if (hold_left > 0) begin
               if (hold_seen == 0) begin
                  hd = o_rsp_dat; hid = int'(o_rsp_id);
               end else if (o_rsp_dat !== hd || int'(o_rsp_id) != hid)
                  hold_viol++;
               if (o_core_val !== 1'b0 || o_busy !== 1'b1) hold_viol++;
               hold_seen++;
               hold_left--;
            end else begin
               rsp_ids.push_back(int'(o_rsp_id));
               rsp_dats.push_back(o_rsp_dat);
               rsp_cyc[o_rsp_id] = cyc;
               got++;
               hold_left = hold;
            end
         end
         @(negedge i_clk);
         cyc++;
         for (int l = 0; l < N; l++) if (hs[l]) begin
            if (bidx[l] == nbeats[l] - 1) begin
               bidx[l] = 0; nmsg[l]--;
            end else bidx[l]++;
         end
      end
      total++;
      if (got < nrsp) begin
         bad++;
         $display("FAIL timeout: responses got=%0d required=%0d", got, nrsp);
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      i_rst = 1'b1;
      #3;
      total++;
      if ({o_req_rdy, o_core_val, o_core_sop, o_core_eop, o_core_byte_len,
           o_core_hash_rdy, o_rsp_id, o_rsp_val, o_err, o_busy} !== '0) begin
         bad++;
         $display("FAIL reset_ctrl: rdy=%b cval=%b rval=%b busy=%b want all 0",
                  o_req_rdy, o_core_val, o_rsp_val, o_busy);
      end
      total++;
      if (o_rsp_dat !== '0 || o_core_dat !== '0) begin
         bad++;
         $display("FAIL reset_data: rsp_dat/core_dat nonzero want 0");
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      #1;
      total++;
      if (o_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_busy: got=%b want=0", o_busy);
      end
   endtask

   task automatic test_abc();
      do_reset(); cfg_clear();
      nmsg[0] = 1; blen[0] = 3; dig[0] = abc_dig;
      run_traffic(1, 200);
      total++;
      if (rsp_ids.size() < 1 || rsp_ids[0] != 0 || rsp_dats[0] !== abc_dig) begin
         bad++;
         $display("FAIL abc_rsp: id=%0d dat=%h want id 0 dat %h",
                  rsp_ids.size() > 0 ? rsp_ids[0] : -1,
                  rsp_dats.size() > 0 ? rsp_dats[0] : '0, abc_dig);
      end
      total++;
      if (err_cnt != 0 || fwd_viol != 0) begin
         bad++;
         $display("FAIL abc_err: err=%0d fwd=%0d want 0 0", err_cnt, fwd_viol);
      end
      total++;
      if (core_cyc - sop_cyc[0] != 1) begin
         bad++;
         $display("FAIL sop_latency: got=%0d want=1", core_cyc - sop_cyc[0]);
      end
      total++;
      if (rval_cyc - hash_cyc != 1) begin
         bad++;
         $display("FAIL hash_latency: got=%0d want=1", rval_cyc - hash_cyc);
      end
      #1;
      total++;
      if (o_busy !== 1'b0 || o_rsp_val !== 1'b0) begin
         bad++;
         $display("FAIL abc_idle: busy=%b rval=%b want 0 0", o_busy, o_rsp_val);
      end
   endtask

   task automatic test_round_robin();
      int exp_ids[5];
      exp_ids = '{0, 1, 2, 3, 1};
      do_reset(); cfg_clear();
      for (int l = 0; l < N; l++) begin
         nmsg[l] = 1; blen[l] = 100;
         dig[l] = {16{32'hD1000000 | 32'(l)}};
      end
      nmsg[1] = 2;
      run_traffic(5, 400);
      for (int k = 0; k < 5; k++) begin
         total++;
         if (k >= rsp_ids.size() || rsp_ids[k] != exp_ids[k] ||
             rsp_dats[k] !== dig[exp_ids[k]]) begin
            bad++;
            $display("FAIL rr_order[%0d]: got=%0d want=%0d", k,
                     k < rsp_ids.size() ? rsp_ids[k] : -1, exp_ids[k]);
         end
      end
      total++;
      if (err_cnt != 0 || fwd_viol != 0) begin
         bad++;
         $display("FAIL rr_err: err=%0d fwd=%0d want 0 0", err_cnt, fwd_viol);
      end
   endtask

   task automatic test_wait_lane();
      do_reset(); cfg_clear();
      nmsg[2] = 1; nbeats[2] = 2; blen[2] = 140;
      dig[2] = {16{32'h2012a869}};
      nmsg[1] = 1; blen[1] = 64; start[1] = 1;
      dig[1] = {16{32'h11110001}};
      run_traffic(2, 300);
      total++;
      if (rsp_ids.size() != 2 || rsp_ids[0] != 2 || rsp_ids[1] != 1) begin
         bad++;
         $display("FAIL wait_order: n=%0d want order 2,1", rsp_ids.size());
      end
      total++;
      if (first_rdy[1] <= rsp_cyc[2]) begin
         bad++;
         $display("FAIL wait_rdy: req1 rdy at %0d, req2 rsp at %0d",
                  first_rdy[1], rsp_cyc[2]);
      end
      total++;
      if (rsp_dats.size() < 1 || rsp_dats[0] !== dig[2] ||
          err_cnt != 0 || fwd_viol != 0) begin
         bad++;
         $display("FAIL wait_2beat: err=%0d fwd=%0d want digest, 0 0",
                  err_cnt, fwd_viol);
      end
   endtask

   task automatic test_resp_hold();
      do_reset(); cfg_clear();
      nmsg[3] = 1; blen[3] = 128; hold = 20;
      dig[3] = {16{32'hCAFE0003}};
      run_traffic(1, 300);
      total++;
      if (hold_seen != 20 || hold_viol != 0) begin
         bad++;
         $display("FAIL resp_hold: seen=%0d viol=%0d want 20 0",
                  hold_seen, hold_viol);
      end
      total++;
      if (rsp_ids.size() != 1 || rsp_ids[0] != 3 || rsp_dats[0] !== dig[3]) begin
         bad++;
         $display("FAIL hold_rsp: n=%0d want one id 3", rsp_ids.size());
      end
      hold = 0;
   endtask

   task automatic test_len_err();
      do_reset(); cfg_clear();
      nmsg[0] = 1; blen[0] = 140; dig[0] = {16{32'hE0000000}};
      run_traffic(1, 200);
      total++;
      if (err_cnt != 1 || rsp_ids.size() != 1 || rsp_ids[0] != 0) begin
         bad++;
         $display("FAIL short_msg: err=%0d n=%0d want err 1 and id 0",
                  err_cnt, rsp_ids.size());
      end
      cfg_clear();
      nmsg[1] = 1; nbeats[1] = 2; blen[1] = 129;
      nmsg[2] = 1; blen[2] = 0;
      run_traffic(2, 300);
      total++;
      if (err_cnt != 0 || rsp_ids.size() != 2) begin
         bad++;
         $display("FAIL len_edge: err=%0d n=%0d want 0 2", err_cnt, rsp_ids.size());
      end
      i_req_val[3] = 1'b1;
      i_req_sop[3] = 1'b0;
      #1;
      total++;
      if (o_err !== 1'b1 || o_req_rdy !== 4'b1000) begin
         bad++;
         $display("FAIL stray_beat: err=%b rdy=%b want 1 1000", o_err, o_req_rdy);
      end
      @(negedge i_clk);
      idle_inputs();
      #1;
      total++;
      if (o_busy !== 1'b0 || o_err !== 1'b0) begin
         bad++;
         $display("FAIL stray_idle: busy=%b err=%b want 0 0", o_busy, o_err);
      end
   endtask

   task automatic test_reset_mid();
      do_reset(); cfg_clear();
      i_req_val[0] = 1'b1; i_req_sop[0] = 1'b1;
      i_req_byte_len[7:0] = 8'd140;
      i_core_rdy = 1'b1;
      @(negedge i_clk);
      #1;
      total++;
      if (o_core_val !== 1'b1 || o_busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_stream: cval=%b busy=%b want 1 1", o_core_val, o_busy);
      end
      i_rst = 1'b1;
      #1;
      total++;
      if (o_core_val !== 1'b0 || o_busy !== 1'b0 || o_req_rdy !== '0 ||
          o_core_dat !== '0 || o_core_byte_len !== '0) begin
         bad++;
         $display("FAIL mid_reset: cval=%b busy=%b rdy=%b want 0",
                  o_core_val, o_busy, o_req_rdy);
      end
      idle_inputs();
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      nmsg[0] = 1; blen[0] = 3; dig[0] = abc_dig;
      run_traffic(1, 200);
      total++;
      if (rsp_ids.size() != 1 || rsp_ids[0] != 0 || rsp_dats[0] !== abc_dig ||
          err_cnt != 0) begin
         bad++;
         $display("FAIL post_reset: n=%0d err=%0d want one id 0 digest",
                  rsp_ids.size(), err_cnt);
      end
   endtask

   initial begin
      abc_std = 512'hba80a53f981c4d0d_6a2797b69f12f6e9_4c212f14685ac4b7_4b12bb6fdbffa2d1_7d87c5392aab792d_c252d5de4533cc95_18d38aa8dbf1925a_b92386edd4009923;
      for (int i = 0; i < 64; i++)
         abc_dig[8*i +: 8] = abc_std[8*(63-i) +: 8];
      cfg_clear();
      test_reset();
      test_abc();
      test_round_robin();
      test_wait_lane();
      test_resp_hold();
      test_len_err();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
